// File: rtl/smoldvi_tmds_encode_pkg.sv
// Shared constants for the TMDS channel encoder: control symbols and the
// running-disparity counter width.
package smoldvi_tmds_encode_pkg;

  localparam int CNT_W = 5;

  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  // Two's-complement disparity held as raw bits; arithmetic wraps at CNT_W.
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
    logic [9:0] sym;
    case (c)
      2'b00:   sym = TMDS_CTRL_00;
      2'b01:   sym = TMDS_CTRL_01;
      2'b10:   sym = TMDS_CTRL_10;
      default: sym = TMDS_CTRL_11;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/smoldvi_tmds_encode_if.sv
// Pixel-side bundle into one TMDS channel encoder and its 10-bit symbol output.
interface smoldvi_tmds_encode_if;
  logic       den;
  logic [7:0] d;
  logic [1:0] c;
  logic [9:0] q;

  modport master (output den, d, c, input q);
  modport slave  (input den, d, c, output q);
endinterface

// File: rtl/smoldvi_tmds_encode_popcount8.sv
// Combinational 8-bit population count.
module smoldvi_tmds_encode_popcount8 (
  input  logic [7:0] i_bits,
  output logic [3:0] o_count
);

  always_comb begin
    o_count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      o_count = o_count + {3'b000, i_bits[i]};
    end
  end

endmodule

// File: rtl/smoldvi_tmds_encode.sv
// TMDS 8b/10b encoder for one DVI channel: stage 1 builds q_m, stage 2 applies
// running-disparity control or emits a control symbol during blanking.
module smoldvi_tmds_encode
  import smoldvi_tmds_encode_pkg::*;
(
  input  logic                 clk_pix,
  input  logic                 rst_n_pix,
  smoldvi_tmds_encode_if.slave tmds
);

  logic [7:0] w_d;
  logic [1:0] w_c;
  logic [3:0] w_n1d;
  logic [3:0] w_n1qm;
  logic       w_use_xnor;
  logic [8:0] w_qm;

  logic [8:0] r_qm;
  logic [3:0] r_n1;
  logic       r_den_s1;
  logic [1:0] r_c_s1;

  logic [9:0] r_q;
  cnt_t       r_cnt;

  logic [9:0] w_q_next;
  cnt_t       w_cnt_next;
  cnt_t       w_diff;
  logic       w_cnt_pos;
  logic       w_cnt_neg;

  // The unselected input is forced to zero so an undriven bus cannot leak in.
  assign w_d = tmds.den ? tmds.d : 8'h00;
  assign w_c = tmds.den ? 2'b00  : tmds.c;

  smoldvi_tmds_encode_popcount8 u_pop_d (
    .i_bits  (w_d),
    .o_count (w_n1d)
  );

  always_comb begin
    w_use_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !w_d[0]);
    w_qm       = 9'd0;
    w_qm[0]    = w_d[0];
    for (int i = 1; i < 8; i++) begin
      w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ w_d[i]) : (w_qm[i-1] ^ w_d[i]);
    end
    w_qm[8] = ~w_use_xnor;
  end

  smoldvi_tmds_encode_popcount8 u_pop_qm (
    .i_bits  (w_qm[7:0]),
    .o_count (w_n1qm)
  );

  always_ff @(posedge clk_pix) begin
    if (!rst_n_pix) begin
      r_qm     <= 9'd0;
      r_n1     <= 4'd0;
      r_den_s1 <= 1'b0;
      r_c_s1   <= 2'b00;
    end else begin
      r_qm     <= w_qm;
      r_n1     <= w_n1qm;
      r_den_s1 <= tmds.den;
      r_c_s1   <= w_c;
    end
  end

  // N1 - N0 = 2*N1 - 8, evaluated in the counter width.
  assign w_diff    = {r_n1, 1'b0} - cnt_t'(8);
  assign w_cnt_neg = r_cnt[CNT_W-1];
  assign w_cnt_pos = !r_cnt[CNT_W-1] && (r_cnt != '0);

  always_comb begin
    w_q_next   = ctrl_symbol(r_c_s1);
    w_cnt_next = '0;
    if (r_den_s1) begin
      if ((r_cnt == '0) || (r_n1 == 4'd4)) begin
        if (r_qm[8]) begin
          w_q_next   = {2'b01, r_qm[7:0]};
          w_cnt_next = r_cnt + w_diff;
        end else begin
          w_q_next   = {2'b10, ~r_qm[7:0]};
          w_cnt_next = r_cnt - w_diff;
        end
      end else if ((w_cnt_pos && (r_n1 > 4'd4)) || (w_cnt_neg && (r_n1 < 4'd4))) begin
        w_q_next   = {1'b1, r_qm[8], ~r_qm[7:0]};
        w_cnt_next = r_cnt + (r_qm[8] ? cnt_t'(2) : cnt_t'(0)) - w_diff;
      end else begin
        w_q_next   = {1'b0, r_qm[8], r_qm[7:0]};
        w_cnt_next = r_cnt - (r_qm[8] ? cnt_t'(0) : cnt_t'(2)) + w_diff;
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_n_pix) begin
      r_q   <= 10'h000;
      r_cnt <= '0;
    end else begin
      r_q   <= w_q_next;
      r_cnt <= w_cnt_next;
    end
  end

  assign tmds.q = r_q;

endmodule
